// File: rtl/id_stage_pkg.sv
// Shared decode-stage definitions: datapath sizes, reset instruction, opcodes
// and the immediate sign-extension helper.
package id_stage_pkg;

  localparam int          ID_DATA_W = 32;
  localparam int          ID_REG_AW = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch <-> decode link: instruction/PC+4 forward, PC control back to fetch.
interface id_stage_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] PCplus4_in;
  logic [DATA_W-1:0] instr_in;
  logic              PCWrite;
  logic              PCSrc;
  logic [DATA_W-1:0] PCBranch;

  modport master (
    output PCplus4_in, instr_in,
    input  PCWrite, PCSrc, PCBranch
  );

  modport slave (
    input  PCplus4_in, instr_in,
    output PCWrite, PCSrc, PCBranch
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file; $0 hardwired to zero, same-cycle write-through.
module id_stage_reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr0_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);
  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register array write; $0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 0 with zero register and write-through bypass
  always_comb begin
    rdata0_o = '0;
    if (raddr0_i == '0) begin
      rdata0_o = '0;
    end else if (we_i && (waddr_i == raddr0_i)) begin
      rdata0_o = wdata_i;
    end else begin
      rdata0_o = regs_q[raddr0_i];
    end
  end

  // Read port 1 with zero register and write-through bypass
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end
endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, register file, hazard detection and zero-cycle
// branch resolution driving PC control back to fetch.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int                DATA_W = ID_DATA_W,
  parameter int                REG_AW = ID_REG_AW,
  parameter logic [DATA_W-1:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  id_stage_if.slave         fetch,
  input  logic              brk,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_result,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pcplus4,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imm_ext,
  output logic [REG_AW-1:0] id_rs,
  output logic [REG_AW-1:0] id_rt,
  output logic [REG_AW-1:0] id_rd
);
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  logic [5:0]        opcode_s;
  logic [REG_AW-1:0] rs_s, rt_s;
  logic [DATA_W-1:0] rf_rs_s, rf_rt_s;
  logic [DATA_W-1:0] rs_cmp_s, rt_cmp_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic              is_beq_s, is_bne_s;
  logic              load_use_s, br_stall_s, stall_s, eq_s, pcsrc_s;

  assign opcode_s  = instr_q[31:26];
  assign rs_s      = instr_q[25:21];
  assign rt_s      = instr_q[20:16];
  assign imm_ext_s = sign_ext16(instr_q[15:0]);
  assign is_beq_s  = (opcode_s == OP_BEQ);
  assign is_bne_s  = (opcode_s == OP_BNE);

  id_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr0_i (rs_s),
    .raddr1_i (rt_s),
    .rdata0_o (rf_rs_s),
    .rdata1_o (rf_rt_s)
  );

  // Hazard detection and branch operand forwarding from a non-load MEM result
  always_comb begin
    load_use_s = ex_memread && (ex_dst != '0) && ((ex_dst == rs_s) || (ex_dst == rt_s));
    br_stall_s = (is_beq_s || is_bne_s) &&
                 ((ex_regwrite && (ex_dst != '0) && ((ex_dst == rs_s) || (ex_dst == rt_s))) ||
                  (mem_memread && (mem_dst != '0) && ((mem_dst == rs_s) || (mem_dst == rt_s))));
    stall_s    = valid_q && (load_use_s || br_stall_s);

    if (mem_regwrite && !mem_memread && (mem_dst != '0) && (mem_dst == rs_s)) begin
      rs_cmp_s = mem_result;
    end else begin
      rs_cmp_s = rf_rs_s;
    end
    if (mem_regwrite && !mem_memread && (mem_dst != '0) && (mem_dst == rt_s)) begin
      rt_cmp_s = mem_result;
    end else begin
      rt_cmp_s = rf_rt_s;
    end

    eq_s    = (rs_cmp_s == rt_cmp_s);
    pcsrc_s = valid_q && !stall_s && ((is_beq_s && eq_s) || (is_bne_s && !eq_s));
  end

  // IF/ID next state: break flush beats branch flush beats stall hold
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (brk || pcsrc_s) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (stall_s) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else begin
      instr_d = fetch.instr_in;
      pc_d    = fetch.PCplus4_in;
      valid_d = 1'b1;
    end
  end

  // IF/ID pipeline latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign fetch.PCWrite  = !stall_s;
  assign fetch.PCSrc    = pcsrc_s;
  assign fetch.PCBranch = pc_q + {imm_ext_s[DATA_W-3:0], 2'b00};

  assign id_valid   = valid_q && !stall_s;
  assign id_pcplus4 = pc_q;
  assign id_instr   = instr_q;
  assign id_rs_data = rf_rs_s;
  assign id_rt_data = rf_rt_s;
  assign id_imm_ext = imm_ext_s;
  assign id_rs      = rs_s;
  assign id_rt      = rt_s;
  assign id_rd      = instr_q[15:11];
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, write-through, load-use, branches,
// forwarding, break flush and mid-stream reset.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        brk, wb_we, ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic [4:0]  wb_addr, ex_dst, mem_dst;
  logic [31:0] wb_data, mem_result;
  logic        id_valid;
  logic [31:0] id_pcplus4, id_instr, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADD_5_0  = 32'h00A0_4820; // add $9,$5,$0
  localparam logic [31:0] ADD_8_10 = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] BEQ_1_2  = 32'h1022_0003; // beq $1,$2,+3
  localparam logic [31:0] BNE_3_4  = 32'h1464_FFFE; // bne $3,$4,-2

  id_stage_if #(.DATA_W(32)) fif ();

  id_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (fif.slave),
    .brk          (brk),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_dst       (ex_dst),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_dst      (mem_dst),
    .mem_result   (mem_result),
    .id_valid     (id_valid),
    .id_pcplus4   (id_pcplus4),
    .id_instr     (id_instr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm_ext   (id_imm_ext),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; brk = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_dst = 5'd0; mem_result = 32'd0;
    fif.instr_in = ADD_8_10; fif.PCplus4_in = 32'h0000_0004;

    // Reset state
    #3;
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pcwrite", {31'd0, fif.PCWrite}, 32'd1);
    chk("rst_pcsrc", {31'd0, fif.PCSrc}, 32'd0);
    #4 rst_n = 1'b1;
    fif.instr_in = 32'h0;

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd5);
    wr(5'd4, 32'd7);
    wr(5'd8, 32'h100);
    wr(5'd10, 32'd3);

    // Write-through and $0
    fif.instr_in = ADD_5_0;
    tick();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    #1;
    chk("wt_rs_same_cycle", id_rs_data, 32'hABCD);
    tick();
    wb_addr = 5'd0; wb_data = 32'd1;
    #1;
    chk("wt_r0_same_cycle", id_rt_data, 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    chk("wt_rs_stored", id_rs_data, 32'hABCD);
    chk("r0_after_write", id_rt_data, 32'd0);
    chk("field_rd", {27'd0, id_rd}, 32'd9);

    // Load-use stall
    fif.instr_in = ADD_8_10; fif.PCplus4_in = 32'h0000_0008;
    tick();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 5'd8;
    fif.instr_in = 32'h012A_5820;
    #1;
    chk("lu_pcwrite", {31'd0, fif.PCWrite}, 32'd0);
    chk("lu_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_pcsrc", {31'd0, fif.PCSrc}, 32'd0);
    tick();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst = 5'd0;
    #1;
    chk("lu_held_instr", id_instr, ADD_8_10);
    chk("lu_issue_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_issue_pcwrite", {31'd0, fif.PCWrite}, 32'd1);
    chk("lu_rs_data", id_rs_data, 32'h100);
    chk("lu_rt_data", id_rt_data, 32'd3);

    // BEQ taken with one-slot flush
    fif.instr_in = BEQ_1_2; fif.PCplus4_in = 32'h0000_0010;
    tick();
    #1;
    chk("beq_pcsrc", {31'd0, fif.PCSrc}, 32'd1);
    chk("beq_target", fif.PCBranch, 32'h0000_001C);
    chk("beq_imm", id_imm_ext, 32'd3);
    chk("beq_valid", {31'd0, id_valid}, 32'd1);
    fif.instr_in = 32'h1234_5678; fif.PCplus4_in = 32'h0000_0014;
    tick();
    #1;
    chk("beq_flush_instr", id_instr, 32'h0);
    chk("beq_flush_valid", {31'd0, id_valid}, 32'd0);

    // BNE with MEM forwarding: $3 forwarded as 7 equals $4, so not taken
    fif.instr_in = BNE_3_4; fif.PCplus4_in = 32'h0000_0040;
    tick();
    mem_regwrite = 1'b1; mem_memread = 1'b0; mem_dst = 5'd3; mem_result = 32'd7;
    #1;
    chk("bne_fwd_pcsrc", {31'd0, fif.PCSrc}, 32'd0);
    chk("bne_imm_neg", id_imm_ext, 32'hFFFF_FFFE);
    chk("bne_target_wrap", fif.PCBranch, 32'h0000_0038);
    chk("bne_rf_rs", id_rs_data, 32'd0);
    mem_regwrite = 1'b0;
    #1;
    chk("bne_nofwd_pcsrc", {31'd0, fif.PCSrc}, 32'd1);
    mem_dst = 5'd0; mem_result = 32'd0;

    // Branch stalls on EX writer and MEM load
    fif.instr_in = BEQ_1_2; fif.PCplus4_in = 32'h0000_0010;
    tick();
    tick();
    ex_regwrite = 1'b1; ex_dst = 5'd2;
    #1;
    chk("bst_ex_pcwrite", {31'd0, fif.PCWrite}, 32'd0);
    chk("bst_ex_pcsrc", {31'd0, fif.PCSrc}, 32'd0);
    chk("bst_ex_valid", {31'd0, id_valid}, 32'd0);
    ex_regwrite = 1'b0; ex_dst = 5'd0;
    mem_memread = 1'b1; mem_dst = 5'd1;
    #1;
    chk("bst_mem_pcwrite", {31'd0, fif.PCWrite}, 32'd0);
    mem_memread = 1'b0; mem_dst = 5'd0;
    #1;
    chk("bst_clear_pcsrc", {31'd0, fif.PCSrc}, 32'd1);

    // Break during load-use stall
    fif.instr_in = ADD_8_10; fif.PCplus4_in = 32'h0000_0020;
    tick();
    tick();
    ex_memread = 1'b1; ex_dst = 5'd10; brk = 1'b1;
    #1;
    chk("brk_stall_pcwrite", {31'd0, fif.PCWrite}, 32'd0);
    tick();
    #1;
    chk("brk_flush_instr", id_instr, 32'h0);
    chk("brk_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("brk_after_pcwrite", {31'd0, fif.PCWrite}, 32'd1);
    brk = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;

    // Reset mid-stream
    tick();
    #1;
    chk("pre_rst_instr", id_instr, ADD_8_10);
    rst_n = 1'b0;
    #1;
    chk("mrst_instr", id_instr, 32'h0);
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_pcwrite", {31'd0, fif.PCWrite}, 32'd1);
    chk("mrst_pcplus4", id_pcplus4, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    #1;
    chk("mrst_rs_zero", id_rs_data, 32'd0);
    chk("mrst_rt_zero", id_rt_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
